// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-path delay-feedback butterfly stage.
// Pairs sample k with sample k+DELAY of each 2*DELAY frame. The stage emits
// saturated sums during the second half of the frame. It emits the stored
// differences during the first half of the following frame.
// Optional build macro: R2SDF_SCALE_EN. When defined, every sum and difference
// is halved (arithmetic shift right by 1), so saturation never occurs.
module r2sdf_stage #(
  parameter int WIDTH = 16,
  parameter int DELAY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_sop,
  output logic             out_ovf,
  output logic             ovf_sticky
);

  localparam int CW = $clog2(2 * DELAY);
  localparam logic [CW-1:0] HALF = CW'(DELAY);
  localparam logic [CW-1:0] LAST = CW'(2 * DELAY - 1);

  logic [CW-1:0]    cnt;
  logic             primed;

  logic [WIDTH-1:0] dl_re  [DELAY];
  logic [WIDTH-1:0] dl_im  [DELAY];
  logic             dl_ovf [DELAY];

  logic [WIDTH-1:0] head_re, head_im;
  logic             head_ovf;
  logic [WIDTH:0]   sr, si, dr, di;
  logic             bfly;

  logic [WIDTH-1:0] push_re, push_im;
  logic             push_ovf;
  logic             nxt_valid, nxt_sop, nxt_ovf;
  logic [WIDTH-1:0] nxt_re, nxt_im;

  // Sign-extend one component to WIDTH+1 bits.
  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  // Reduce a WIDTH+1-bit result to WIDTH bits; the MSB of the return value is the clamp flag.
  function automatic logic [WIDTH:0] clip(input logic [WIDTH:0] v);
`ifdef R2SDF_SCALE_EN
    return {1'b0, v[WIDTH:1]};
`else
    if (v[WIDTH] != v[WIDTH-1])
      return {1'b1, v[WIDTH], {(WIDTH-1){~v[WIDTH]}}};
    else
      return {1'b0, v[WIDTH-1:0]};
`endif
  endfunction

  // Butterfly arithmetic and selection between fill-phase and butterfly-phase outputs.
  always_comb begin
    head_re  = dl_re[DELAY-1];
    head_im  = dl_im[DELAY-1];
    head_ovf = dl_ovf[DELAY-1];
    sr       = clip(ext(head_re) + ext(in_real));
    si       = clip(ext(head_im) + ext(in_imag));
    dr       = clip(ext(head_re) - ext(in_real));
    di       = clip(ext(head_im) - ext(in_imag));
    bfly     = (cnt >= HALF);

    push_re   = in_real;
    push_im   = in_imag;
    push_ovf  = 1'b0;
    nxt_valid = primed;
    nxt_sop   = 1'b0;
    nxt_re    = head_re;
    nxt_im    = head_im;
    nxt_ovf   = primed & head_ovf;

    if (bfly) begin
      push_re   = dr[WIDTH-1:0];
      push_im   = di[WIDTH-1:0];
      push_ovf  = dr[WIDTH] | di[WIDTH];
      nxt_valid = 1'b1;
      nxt_sop   = (cnt == HALF);
      nxt_re    = sr[WIDTH-1:0];
      nxt_im    = si[WIDTH-1:0];
      nxt_ovf   = sr[WIDTH] | si[WIDTH];
    end
  end

  // Delay line: shift by one entry for each accepted sample. Each entry carries its write-time clamp bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        dl_re[i]  <= '0;
        dl_im[i]  <= '0;
        dl_ovf[i] <= 1'b0;
      end
    end else if (in_valid) begin
      for (int unsigned i = 1; i < DELAY; i++) begin
        dl_re[i]  <= dl_re[i-1];
        dl_im[i]  <= dl_im[i-1];
        dl_ovf[i] <= dl_ovf[i-1];
      end
      dl_re[0]  <= push_re;
      dl_im[0]  <= push_im;
      dl_ovf[0] <= push_ovf;
    end
  end

  // Frame counter and primed flag; both advance only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      if (cnt == LAST) begin
        cnt    <= '0;
        primed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output register. On a stall, valid and sop drop and the data outputs hold their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_ovf   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else if (in_valid) begin
      out_valid <= nxt_valid;
      out_sop   <= nxt_sop;
      out_ovf   <= nxt_ovf;
      out_real  <= nxt_re;
      out_imag  <= nxt_im;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
    end
  end

  // Sticky overflow flag. A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (in_valid && nxt_valid && nxt_ovf)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench for r2sdf_stage with DELAY=4. Expected values are hand-derived;
// the scaled expectations are selected when R2SDF_SCALE_EN is defined.
module tb_r2sdf_stage;

  localparam int W = 16;
  localparam int D = 4;
`ifdef R2SDF_SCALE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;
  logic         ovf_clr = 1'b0;
  logic         out_valid, out_sop, out_ovf, ovf_sticky;
  logic [W-1:0] out_real, out_imag;

  r2sdf_stage #(.WIDTH(W), .DELAY(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
    .out_sop(out_sop), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] re, im;
    logic         ev;
    logic [W-1:0] ere, eim;
    logic         esop, eovf, estk;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int sop_count;
  vec_t basic [12];
  vec_t sat   [12];

  function automatic vec_t mk(input logic v, input int re, input int im, input logic ev,
                              input int ere, input int eim, input logic sop,
                              input logic ovf, input logic stk);
    vec_t t;
    t.v = v; t.re = 16'(re); t.im = 16'(im); t.ev = ev;
    t.ere = 16'(ere); t.eim = 16'(eim); t.esop = sop; t.eovf = ovf; t.estk = stk;
    return t;
  endfunction

  function automatic int scl(input int x);
    return x >>> SH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    in_valid = v; in_real = re; in_imag = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_real = 16'h1234; in_imag = 16'h4321; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic apply(input vec_t t, input string tag, input int idx);
    drive(t.v, t.re, t.im);
    if (out_sop === 1'b1) sop_count++;
    chk($sformatf("%s[%0d].valid", tag, idx), {31'd0, out_valid}, {31'd0, t.ev});
    chk($sformatf("%s[%0d].sop", tag, idx), {31'd0, out_sop}, {31'd0, t.esop});
    chk($sformatf("%s[%0d].sticky", tag, idx), {31'd0, ovf_sticky}, {31'd0, t.estk});
    if (t.ev) begin
      chk($sformatf("%s[%0d].re", tag, idx), {16'd0, out_real}, {16'd0, t.ere});
      chk($sformatf("%s[%0d].im", tag, idx), {16'd0, out_imag}, {16'd0, t.eim});
      chk($sformatf("%s[%0d].ovf", tag, idx), {31'd0, out_ovf}, {31'd0, t.eovf});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // basic butterfly: real 1..8 then four zeros
    for (int i = 0; i < 4; i++)  basic[i] = mk(1, i + 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 4; i < 8; i++)  basic[i] = mk(1, i + 1, 0, 1, scl(2 * i - 2), 0, i == 4, 0, 0);
    for (int i = 8; i < 12; i++) basic[i] = mk(1, 0, 0, 1, scl(-4), 0, 0, 0, 0);

    // reset state
    do_reset();
    chk("rst.valid",  {31'd0, out_valid},  32'd0);
    chk("rst.sop",    {31'd0, out_sop},    32'd0);
    chk("rst.ovf",    {31'd0, out_ovf},    32'd0);
    chk("rst.sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst.re",     {16'd0, out_real},   32'd0);
    chk("rst.im",     {16'd0, out_imag},   32'd0);

    for (int i = 0; i < 12; i++) apply(basic[i], "basic", i);

    // stalls: random idle gaps must not change results
    do_reset();
    for (int i = 0; i < 12; i++) begin
      int g;
      g = int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        chk($sformatf("stall[%0d].valid", i), {31'd0, out_valid}, 32'd0);
        chk($sformatf("stall[%0d].sop", i),   {31'd0, out_sop},   32'd0);
      end
      apply(basic[i], "stall", i);
    end

    // reset mid-frame, then replay
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 16'(100 + i), 16'(7 * i));
    do_reset();
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 12; i++) apply(basic[i], "midrst", i);

`ifndef R2SDF_SCALE_EN
    // saturation on a sum (pair 0) and on a stored difference (pair 1)
    sat[0]  = mk(1, 'h7000, 'h9000, 0, 0, 0, 0, 0, 0);
    sat[1]  = mk(1, 'h7000, 0, 0, 0, 0, 0, 0, 0);
    sat[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sat[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sat[4]  = mk(1, 'h7000, 'h9000, 1, 'h7FFF, 'h8000, 1, 1, 1);
    sat[5]  = mk(1, 'h9000, 0, 1, 0, 0, 0, 0, 1);
    sat[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
    sat[7]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
    sat[8]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
    sat[9]  = mk(1, 0, 0, 1, 'h7FFF, 0, 0, 1, 1);
    sat[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
    sat[11] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
`else
    // scaled build: halved results, no clamping
    sat[0]  = mk(1, 'h7000, 0, 0, 0, 0, 0, 0, 0);
    sat[1]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0);
    sat[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sat[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sat[4]  = mk(1, 'h7000, 0, 1, 'h7000, 0, 1, 0, 0);
    sat[5]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
    sat[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    sat[7]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    sat[8]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    sat[9]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
    sat[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    sat[11] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
`endif
    do_reset();
    for (int i = 0; i < 12; i++) apply(sat[i], "sat", i);
    drive(1'b0, 0, 0);
    chk("sticky.hold", {31'd0, ovf_sticky}, {31'd0, sat[11].estk});
    ovf_clr = 1'b1;
    drive(1'b0, 0, 0);
    ovf_clr = 1'b0;
    chk("sticky.clr", {31'd0, ovf_sticky}, 32'd0);

    // back-to-back frames: x_i = (f+1)*(i+1) + j*-(i+1)
    do_reset();
    sop_count = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        vec_t t;
        if (i < 4) begin
          if (f == 0) t = mk(1, (f + 1) * (i + 1), -(i + 1), 0, 0, 0, 0, 0, 0);
          else        t = mk(1, (f + 1) * (i + 1), -(i + 1), 1, scl(-4 * f), scl(4), 0, 0, 0);
        end else begin
          t = mk(1, (f + 1) * (i + 1), -(i + 1), 1, scl((f + 1) * (2 * i - 2)),
                 scl(-(2 * i - 2)), i == 4, 0, 0);
        end
        apply(t, $sformatf("b2b.f%0d", f), i);
      end
    end
    for (int i = 0; i < 4; i++) apply(mk(1, 0, 0, 1, scl(-12), scl(4), 0, 0, 0), "b2b.flush", i);
    chk("b2b.sop_count", sop_count, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
